// File: rtl/free_list_pkg.sv
// free_list_pkg: default sizes and tag type shared by the physical-register free list
package free_list_pkg;
  localparam int NUM_PREGS_DEF = 64;
  localparam int NUM_AREGS_DEF = 32;
  localparam int DEPTH_DEF = NUM_PREGS_DEF - NUM_AREGS_DEF;
  localparam int TAG_W_DEF = $clog2(NUM_PREGS_DEF);
  localparam int CNT_W_DEF = $clog2(DEPTH_DEF + 1);
  typedef logic [TAG_W_DEF-1:0] preg_tag_t;
endpackage

// File: rtl/phys_reg_free_list_if.sv
// phys_reg_free_list_if: rename alloc and commit free ports of the free list
interface phys_reg_free_list_if import free_list_pkg::*; #(
  parameter int TAG_W = TAG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic alloc_req, alloc_valid, alloc_fire, free_en, overflow_err, dbl_free_err;
  logic [TAG_W-1:0] alloc_tag, free_tag;
  logic [CNT_W-1:0] free_count;
  modport master(output alloc_req, free_en, free_tag,
                 input alloc_valid, alloc_tag, alloc_fire, free_count, overflow_err, dbl_free_err);
  modport slave(input alloc_req, free_en, free_tag,
                output alloc_valid, alloc_tag, alloc_fire, free_count, overflow_err, dbl_free_err);
endinterface

// File: rtl/fl_wrap_ptr.sv
// fl_wrap_ptr: pointer that advances on adv and wraps from DEPTH-1 to 0
module fl_wrap_ptr #(
  parameter int DEPTH = 32,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         adv,
  output logic [W-1:0] ptr
);
  always_ff @(posedge clk)
    ptr <= reset ? '0 : !adv ? ptr : ptr == W'(DEPTH - 1) ? '0 : ptr + W'(1);
endmodule

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: circular FIFO of free physical tags; FREE_LIST_DBL_FREE_CHECK_EN adds double-free detection
module phys_reg_free_list import free_list_pkg::*; #(
  parameter int NUM_PREGS = NUM_PREGS_DEF,
  parameter int NUM_AREGS = NUM_AREGS_DEF
) (
  input logic clk,
  input logic reset,
  phys_reg_free_list_if.slave fl
);
  localparam int DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int TAG_W = $clog2(NUM_PREGS);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic full, free_ok, dbl_hit, ovf_err;
  assign full = count == CNT_W'(DEPTH);
  assign fl.alloc_valid = count != '0;
  assign fl.alloc_tag = mem[head];
  assign fl.alloc_fire = fl.alloc_req && fl.alloc_valid;
  assign fl.free_count = count;
  assign fl.overflow_err = ovf_err;
  assign free_ok = fl.free_en && !full && !dbl_hit;
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
  logic [NUM_PREGS-1:0] in_list;
  logic dbl_err;
  assign dbl_hit = fl.free_en && in_list[fl.free_tag];
  assign fl.dbl_free_err = dbl_err;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) in_list[i] <= i >= NUM_AREGS;
      dbl_err <= 1'b0;
    end else begin
      if (fl.alloc_fire) in_list[fl.alloc_tag] <= 1'b0;
      if (free_ok) in_list[fl.free_tag] <= 1'b1;
      dbl_err <= dbl_err || dbl_hit;
    end
  end
`else
  assign dbl_hit = 1'b0;
  assign fl.dbl_free_err = 1'b0;
`endif
  fl_wrap_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_head (.clk(clk), .reset(reset), .adv(fl.alloc_fire), .ptr(head));
  fl_wrap_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_tail (.clk(clk), .reset(reset), .adv(free_ok), .ptr(tail));
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= TAG_W'(NUM_AREGS + i);
    end else if (free_ok) begin
      mem[tail] <= fl.free_tag;
    end
    count <= reset ? CNT_W'(DEPTH) :
             (free_ok && !fl.alloc_fire) ? count + CNT_W'(1) :
             (fl.alloc_fire && !free_ok) ? count - CNT_W'(1) : count;
    ovf_err <= !reset && (ovf_err || (fl.free_en && full));
  end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb_phys_reg_free_list: scoreboard bench; alloc tags checked by a monitor against queued expectations
module tb_phys_reg_free_list;
  import free_list_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int exp_q[$];
  phys_reg_free_list_if fl();
  phys_reg_free_list dut (.clk(clk), .reset(reset), .fl(fl));
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction
  always @(negedge clk)
    if (!reset && fl.alloc_fire === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_alloc: got tag %0d expected no alloc", fl.alloc_tag);
      end else chk("alloc_tag", 32'(fl.alloc_tag), exp_q.pop_front());
    end
  task automatic go(input logic ar, input logic fe, input preg_tag_t ft);
    fl.alloc_req = ar;
    fl.free_en = fe;
    fl.free_tag = ft;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    go(1'b0, 1'b0, '0);
  endtask
  task automatic cyc(input logic ar, input logic fe, input preg_tag_t ft);
    go(ar, fe, ft);
    tick();
  endtask
  task automatic alloc(input int e);
    exp_q.push_back(e);
    cyc(1'b1, 1'b0, '0);
  endtask
  initial begin
    go(1'b0, 1'b0, '0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_count", 32'(fl.free_count), 32);
    chk("rst_valid", 32'(fl.alloc_valid), 1);
    chk("rst_tag", 32'(fl.alloc_tag), 32);
    chk("rst_ovf", 32'(fl.overflow_err), 0);
    chk("rst_dbl", 32'(fl.dbl_free_err), 0);
    for (int i = 0; i < 32; i++) begin
      if (i == 16) chk("half_count", 32'(fl.free_count), 16);
      alloc(32 + i);
    end
    chk("empty_count", 32'(fl.free_count), 0);
    chk("empty_valid", 32'(fl.alloc_valid), 0);
    go(1'b1, 1'b1, preg_tag_t'(5));
    #1;
    chk("empty_fire", 32'(fl.alloc_fire), 0);
    chk("empty_valid_free", 32'(fl.alloc_valid), 0);
    tick();
    chk("nobypass_tag", 32'(fl.alloc_tag), 5);
    chk("nobypass_count", 32'(fl.free_count), 1);
    alloc(5);
    chk("reempty_count", 32'(fl.free_count), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc(1'b0, 1'b1, preg_tag_t'(7));
    chk("ovf_err", 32'(fl.overflow_err), 1);
    chk("ovf_count", 32'(fl.free_count), 32);
    chk("ovf_tag", 32'(fl.alloc_tag), 32);
    exp_q.push_back(32);
    cyc(1'b1, 1'b1, preg_tag_t'(9));
    chk("full_fire_free_count", 32'(fl.free_count), 31);
    chk("full_fire_free_tag", 32'(fl.alloc_tag), 33);
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(i < 31 ? 33 + i : i - 31);
      cyc(1'b1, 1'b1, preg_tag_t'(i));
      if (i % 10 == 9) chk("steady_count", 32'(fl.free_count), 31);
    end
    for (int i = 0; i < 31; i++) alloc(9 + i);
    chk("drain_count", 32'(fl.free_count), 0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, preg_tag_t'(40 + i));
    chk("pre_rst_count", 32'(fl.free_count), 10);
    chk("pre_rst_ovf", 32'(fl.overflow_err), 1);
    reset = 1'b1;
    go(1'b1, 1'b1, preg_tag_t'(3));
    tick();
    reset = 1'b0;
    chk("mid_rst_count", 32'(fl.free_count), 32);
    chk("mid_rst_tag", 32'(fl.alloc_tag), 32);
    chk("mid_rst_valid", 32'(fl.alloc_valid), 1);
    chk("mid_rst_ovf", 32'(fl.overflow_err), 0);
    chk("mid_rst_dbl", 32'(fl.dbl_free_err), 0);
    alloc(32);
    alloc(33);
    cyc(1'b0, 1'b1, preg_tag_t'(32));
    chk("free1_count", 32'(fl.free_count), 31);
    cyc(1'b0, 1'b1, preg_tag_t'(32));
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
    chk("dbl_err", 32'(fl.dbl_free_err), 1);
    chk("dbl_count", 32'(fl.free_count), 31);
`else
    chk("dbl_err", 32'(fl.dbl_free_err), 0);
    chk("dbl_count", 32'(fl.free_count), 32);
`endif
    for (int i = 0; i < 30; i++) alloc(34 + i);
    alloc(32);
`ifndef FREE_LIST_DBL_FREE_CHECK_EN
    alloc(32);
`endif
    chk("final_count", 32'(fl.free_count), 0);
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end
endmodule
